// File: rtl/decode_queue_pkg.sv
// Shared widths, opcodes and the packed decoded-entry layout for the decode queue.
// Instruction word: op[27:24] rd[23:20] rs2[19:16] rs1_imm[15:0].
package decode_queue_pkg;
  localparam int INST_LEN      = 28;
  localparam int INST_SIZE_LOG = 4;
  localparam int MEMI_SIZE_LOG = 8;
  localparam int REG_LEN       = 16;
  localparam int RF_SIZE_LOG   = 4;

  localparam logic [INST_SIZE_LOG-1:0] INST_OP_LI  = 4'd0;
  localparam logic [INST_SIZE_LOG-1:0] INST_OP_ADD = 4'd1;
  localparam logic [INST_SIZE_LOG-1:0] INST_OP_MUL = 4'd2;
  localparam logic [INST_SIZE_LOG-1:0] INST_OP_LD  = 4'd3;
  localparam logic [INST_SIZE_LOG-1:0] INST_OP_ST  = 4'd4;
  localparam logic [INST_SIZE_LOG-1:0] INST_OP_BR  = 4'd5;

  typedef struct packed {
    logic [MEMI_SIZE_LOG-1:0] pc;
    logic [INST_SIZE_LOG-1:0] opcode;
    logic                     rs1_used;
    logic                     rs2_used;
    logic [REG_LEN-1:0]       rs1_imm;
    logic [RF_SIZE_LOG-1:0]   rs1;
    logic [RF_SIZE_LOG-1:0]   rs2;
    logic [MEMI_SIZE_LOG-1:0] br_offset;
    logic                     wen;
    logic                     rd_data_use_execute;
    logic [RF_SIZE_LOG-1:0]   rd;
    logic                     mem_valid;
    logic                     mem_rdwt;
    logic                     is_br;
    logic                     illegal;
  } dq_entry_t;

  localparam int DQ_ENTRY_LEN = $bits(dq_entry_t);
endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side and issue-side handshake bundle of the decode queue.
interface decode_queue_if #(parameter int DEPTH = 4);
  import decode_queue_pkg::*;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                     in_valid, in_ready, flush;
  logic [INST_LEN-1:0]      in_inst;
  logic [MEMI_SIZE_LOG-1:0] in_pc;
  logic                     out_valid, out_ready;
  logic [MEMI_SIZE_LOG-1:0] out_pc, out_rs1_br_offset;
  logic [INST_SIZE_LOG-1:0] out_opcode;
  logic                     out_rs1_used, out_rs2_used;
  logic [REG_LEN-1:0]       out_rs1_imm;
  logic [RF_SIZE_LOG-1:0]   out_rs1, out_rs2, out_rd;
  logic                     out_wen, out_rd_data_use_execute;
  logic                     out_mem_valid, out_mem_rdwt, out_is_br, out_illegal;
  logic [CNT_W-1:0]         count;

  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rs1_used, out_rs2_used,
           out_rs1_imm, out_rs1, out_rs2, out_rs1_br_offset, out_wen,
           out_rd_data_use_execute, out_rd, out_mem_valid, out_mem_rdwt,
           out_is_br, out_illegal, count
  );
  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rs1_used, out_rs2_used,
           out_rs1_imm, out_rs1, out_rs2, out_rs1_br_offset, out_wen,
           out_rd_data_use_execute, out_rd, out_mem_valid, out_mem_rdwt,
           out_is_br, out_illegal, count
  );
endinterface

// File: rtl/decode_queue_inst_field_dec.sv
// Combinational raw-instruction to decoded-entry decoder with illegal-opcode flag.
module inst_field_dec
  import decode_queue_pkg::*;
(
  input  logic [INST_LEN-1:0]      inst_i,
  input  logic [MEMI_SIZE_LOG-1:0] pc_i,
  output dq_entry_t                entry_o
);
  always_comb begin
    entry_o           = '0;
    entry_o.pc        = pc_i;
    entry_o.opcode    = inst_i[27:24];
    entry_o.rd        = inst_i[23:20];
    entry_o.rs2       = inst_i[19:16];
    entry_o.rs1_imm   = inst_i[15:0];
    entry_o.rs1       = inst_i[3:0];
    entry_o.br_offset = inst_i[7:0];
    case (inst_i[27:24])
      INST_OP_LI:  begin entry_o.wen = 1'b1; entry_o.rd_data_use_execute = 1'b1; end
      INST_OP_ADD, INST_OP_MUL: begin
        entry_o.rs1_used = 1'b1; entry_o.rs2_used = 1'b1;
        entry_o.wen = 1'b1; entry_o.rd_data_use_execute = 1'b1;
      end
      INST_OP_LD: begin
        entry_o.rs1_used = 1'b1; entry_o.wen = 1'b1;
        entry_o.mem_valid = 1'b1; entry_o.mem_rdwt = 1'b1;
      end
      INST_OP_ST: begin
        entry_o.rs1_used = 1'b1; entry_o.rs2_used = 1'b1; entry_o.mem_valid = 1'b1;
      end
      INST_OP_BR:  begin entry_o.rs2_used = 1'b1; entry_o.is_br = 1'b1; end
      // Unknown encodings keep their raw fields but assert no side effects.
      default:     entry_o.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/decode_queue.sv
// Registered decode stage: decode on enqueue into a circular FIFO, issue via valid/ready.
// Optional same-cycle bypass on an empty queue: DECODE_QUEUE_BYPASS_EN.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  decode_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  dq_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  dq_entry_t        dec_entry, head_entry;
  logic             byp, enq, deq, out_vld;

  inst_field_dec u_dec (.inst_i(bus.in_inst), .pc_i(bus.in_pc), .entry_o(dec_entry));

  assign bus.in_ready = (count_q != CNT_W'(DEPTH));
`ifdef DECODE_QUEUE_BYPASS_EN
  assign byp = (count_q == '0) && bus.in_valid && !bus.flush;
`else
  assign byp = 1'b0;
`endif
  assign out_vld = (count_q != '0) || byp;
  assign deq     = (count_q != '0) && bus.out_ready;
  // A bypassed instruction taken by issue this cycle never lands in storage.
  assign enq     = bus.in_valid && bus.in_ready && !(byp && bus.out_ready);

  always_comb begin
    head_entry = '0;
    if (byp)                 head_entry = dec_entry;
    else if (count_q != '0)  head_entry = mem_q[head_q];
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) tail_d = tail_q + PTR_W'(1);
    if (deq) head_d = head_q + PTR_W'(1);
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq && !bus.flush && !rst) mem_q[tail_q] <= dec_entry;
  end

  assign bus.out_valid               = out_vld;
  assign bus.out_pc                  = head_entry.pc;
  assign bus.out_opcode              = head_entry.opcode;
  assign bus.out_rs1_used            = head_entry.rs1_used;
  assign bus.out_rs2_used            = head_entry.rs2_used;
  assign bus.out_rs1_imm             = head_entry.rs1_imm;
  assign bus.out_rs1                 = head_entry.rs1;
  assign bus.out_rs2                 = head_entry.rs2;
  assign bus.out_rs1_br_offset       = head_entry.br_offset;
  assign bus.out_wen                 = head_entry.wen;
  assign bus.out_rd_data_use_execute = head_entry.rd_data_use_execute;
  assign bus.out_rd                  = head_entry.rd;
  assign bus.out_mem_valid           = head_entry.mem_valid;
  assign bus.out_mem_rdwt            = head_entry.mem_rdwt;
  assign bus.out_is_br               = head_entry.is_br;
  assign bus.out_illegal             = head_entry.illegal;
  assign bus.count                   = count_q;
endmodule

// File: tb/tb_decode_queue.sv
// Directed scoreboard bench for decode_queue (DEPTH=4).
module tb_decode_queue;
  import decode_queue_pkg::*;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_queue_if #(.DEPTH(DEPTH)) bus ();
  decode_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  dq_entry_t sb[$];
  int npass = 0, nfail = 0, ntot = 0;

  function automatic logic [INST_LEN-1:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                             input logic [3:0] rs2, input logic [15:0] imm);
    return {op, rd, rs2, imm};
  endfunction

  // Expected decode: flags {rs1u, rs2u, wen, rdx, memv, rdwt, br} per opcode.
  function automatic dq_entry_t exp_entry(input logic [INST_LEN-1:0] inst,
                                          input logic [MEMI_SIZE_LOG-1:0] pc);
    dq_entry_t e;
    logic [6:0] f;
    e = '0;
    e.pc = pc; e.opcode = inst[27:24]; e.rd = inst[23:20]; e.rs2 = inst[19:16];
    e.rs1_imm = inst[15:0]; e.rs1 = inst[3:0]; e.br_offset = inst[7:0];
    case (inst[27:24])
      4'd0:    f = 7'b0011000;
      4'd1:    f = 7'b1111000;
      4'd2:    f = 7'b1111000;
      4'd3:    f = 7'b1010110;
      4'd4:    f = 7'b1100100;
      4'd5:    f = 7'b0100001;
      default: begin f = 7'b0000000; e.illegal = 1'b1; end
    endcase
    {e.rs1_used, e.rs2_used, e.wen, e.rd_data_use_execute, e.mem_valid, e.mem_rdwt, e.is_br} = f;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input dq_entry_t e);
    chk("out_pc",      32'(bus.out_pc), 32'(e.pc));
    chk("out_opcode",  32'(bus.out_opcode), 32'(e.opcode));
    chk("out_rs1_used", 32'(bus.out_rs1_used), 32'(e.rs1_used));
    chk("out_rs2_used", 32'(bus.out_rs2_used), 32'(e.rs2_used));
    chk("out_rs1_imm", 32'(bus.out_rs1_imm), 32'(e.rs1_imm));
    chk("out_rs1",     32'(bus.out_rs1), 32'(e.rs1));
    chk("out_rs2",     32'(bus.out_rs2), 32'(e.rs2));
    chk("out_br_off",  32'(bus.out_rs1_br_offset), 32'(e.br_offset));
    chk("out_wen",     32'(bus.out_wen), 32'(e.wen));
    chk("out_rdx",     32'(bus.out_rd_data_use_execute), 32'(e.rd_data_use_execute));
    chk("out_rd",      32'(bus.out_rd), 32'(e.rd));
    chk("out_mem_valid", 32'(bus.out_mem_valid), 32'(e.mem_valid));
    chk("out_mem_rdwt", 32'(bus.out_mem_rdwt), 32'(e.mem_rdwt));
    chk("out_is_br",   32'(bus.out_is_br), 32'(e.is_br));
    chk("out_illegal", 32'(bus.out_illegal), 32'(e.illegal));
  endtask

  // One clock cycle: drive, check against the scoreboard, then advance past the edge.
  task automatic do_cycle(input logic iv, input logic [INST_LEN-1:0] inst,
                          input logic [MEMI_SIZE_LOG-1:0] pc, input logic ordy, input logic fl);
    int  pre;
    bit  byp_exp, vld;
    bus.in_valid = iv; bus.in_inst = inst; bus.in_pc = pc;
    bus.out_ready = ordy; bus.flush = fl;
    #1;
    pre = sb.size();
    byp_exp = 1'b0;
`ifdef DECODE_QUEUE_BYPASS_EN
    byp_exp = (pre == 0) && iv && !fl;
`endif
    vld = (pre != 0) || byp_exp;
    chk("count",     32'(bus.count), 32'(pre));
    chk("in_ready",  32'(bus.in_ready), 32'(pre != DEPTH));
    chk("out_valid", 32'(bus.out_valid), 32'(vld));
    if (iv && pre != DEPTH && !fl) sb.push_back(exp_entry(inst, pc));
    if (vld) check_head(sb[0]);
    else     check_head('0);
    if (vld && ordy && !fl) void'(sb.pop_front());
    if (fl) sb.delete();
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic ordy);
    do_cycle(1'b0, '0, '0, ordy, 1'b0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0;
    bus.out_ready = 1'b0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
    chk("rst_count",     32'(bus.count), 32'd0);
    check_head('0);

    // Fill with ADD, LI, LD, ST while issue stalls; a fifth offer must be refused.
    do_cycle(1'b1, mk(4'd1, 4'd3, 4'd2, 16'h0001), 8'h10, 1'b0, 1'b0);
    do_cycle(1'b1, mk(4'd0, 4'd4, 4'd0, 16'h1234), 8'h11, 1'b0, 1'b0);
    do_cycle(1'b1, mk(4'd3, 4'd5, 4'd0, 16'h0007), 8'h12, 1'b0, 1'b0);
    do_cycle(1'b1, mk(4'd4, 4'd0, 4'd6, 16'h0008), 8'h13, 1'b0, 1'b0);
    chk("full_count", 32'(bus.count), 32'd4);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    do_cycle(1'b1, mk(4'd2, 4'd9, 4'd9, 16'h0009), 8'h14, 1'b1, 1'b0);
    repeat (4) idle(1'b1);
    chk("drained_count", 32'(bus.count), 32'd0);

    // Steady enqueue+dequeue at occupancy 2, wrapping the pointers.
    do_cycle(1'b1, mk(4'd0, 4'd1, 4'd0, 16'h00a0), 8'h20, 1'b0, 1'b0);
    do_cycle(1'b1, mk(4'd0, 4'd2, 4'd0, 16'h00a1), 8'h21, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      do_cycle(1'b1, mk(4'(i % 6), 4'(i), 4'(i + 1), 16'(16'h0b00 + i)), 8'(8'h30 + i), 1'b1, 1'b0);
    chk("steady_count", 32'(bus.count), 32'd2);
    repeat (2) idle(1'b1);

    // Flush at occupancy 3 with a live enqueue and dequeue: both discarded.
    for (int i = 0; i < 3; i++)
      do_cycle(1'b1, mk(4'd1, 4'(i), 4'd1, 16'(i)), 8'(8'h40 + i), 1'b0, 1'b0);
    do_cycle(1'b1, mk(4'd2, 4'd7, 4'd7, 16'hdead), 8'h4f, 1'b1, 1'b1);
    chk("flush_count", 32'(bus.count), 32'd0);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    do_cycle(1'b1, mk(4'd0, 4'd8, 4'd0, 16'h5555), 8'h50, 1'b0, 1'b0);
    idle(1'b1);

    // Illegal encoding then BR.
    do_cycle(1'b1, mk(4'hf, 4'd5, 4'd6, 16'hbeef), 8'h60, 1'b0, 1'b0);
    do_cycle(1'b1, mk(4'd5, 4'd0, 4'd3, 16'h00f8), 8'h61, 1'b0, 1'b0);
    chk("illegal_flag", 32'(bus.out_illegal), 32'd1);
    idle(1'b1);
    chk("br_is_br", 32'(bus.out_is_br), 32'd1);
    chk("br_wen", 32'(bus.out_wen), 32'd0);
    idle(1'b1);

    // Reset mid-stream at occupancy 2.
    do_cycle(1'b1, mk(4'd1, 4'd1, 4'd1, 16'h0001), 8'h70, 1'b0, 1'b0);
    do_cycle(1'b1, mk(4'd1, 4'd2, 4'd2, 16'h0002), 8'h71, 1'b0, 1'b0);
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    chk("rst2_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst2_in_ready",  32'(bus.in_ready), 32'd1);
    chk("rst2_count",     32'(bus.count), 32'd0);
    check_head('0);
    do_cycle(1'b1, mk(4'd3, 4'd6, 4'd0, 16'h0044), 8'h80, 1'b0, 1'b0);
    chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
    idle(1'b1);

`ifdef DECODE_QUEUE_BYPASS_EN
    // Bypass: MUL consumed from an empty queue in the same cycle.
    do_cycle(1'b1, mk(4'd2, 4'd3, 4'd4, 16'h0005), 8'h90, 1'b1, 1'b0);
    chk("bypass_count", 32'(bus.count), 32'd0);
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Registered decode stage with a parametrised-depth buffer between fetch and issue in the simpleooo core.
- Each accepted instruction is decoded once on entry and stored as a decoded entry in a circular FIFO.
- Issue reads the head entry through a valid/ready handshake.
- Adds what the plain combinational decoder lacks: buffering, backpressure, squash/flush, illegal-opcode detection and occupancy reporting.

Parameters:
- DEPTH, 4, number of decoded entries; power of two, >= 2.
- PTR_W, $clog2(DEPTH), head/tail pointer width (localparam, derived).
- CNT_W, $clog2(DEPTH+1), occupancy counter width (localparam, derived).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept; equals (count != DEPTH), registered state only.
- in_inst  in  `INST_LEN  raw instruction.
- in_pc  in  `MEMI_SIZE_LOG  instruction PC.
- flush  in  1  squash all entries; mispredict or exception.
- out_valid  out  1  head entry valid.
- out_ready  in  1  issue consumes the head.
- out_pc  out  `MEMI_SIZE_LOG  head PC.
- out_opcode  out  `INST_SIZE_LOG  head opcode.
- out_rs1_used, out_rs2_used  out  1 each  source-use flags.
- out_rs1_imm  out  `REG_LEN  rs1 field / immediate.
- out_rs1, out_rs2  out  `RF_SIZE_LOG each  source registers.
- out_rs1_br_offset  out  `MEMI_SIZE_LOG  branch offset.
- out_wen, out_rd_data_use_execute  out  1 each  writeback controls.
- out_rd  out  `RF_SIZE_LOG  destination register.
- out_mem_valid, out_mem_rdwt  out  1 each  memory op and direction (1 = load).
- out_is_br  out  1  branch.
- out_illegal  out  1  opcode outside {LI, ADD, MUL, LD, ST, BR}.
- count  out  CNT_W  current occupancy.

Behaviour:
- Decode at enqueue; field semantics per opcode:
  - rs1_used: ADD, MUL, LD, ST.
  - rs2_used: ADD, MUL, ST, BR.
  - wen: LI, ADD, MUL, LD.
  - rd_data_use_execute: LI, ADD, MUL.
  - mem_valid: LD, ST. mem_rdwt: LD.
  - is_br: BR.
- Illegal opcode: illegal=1; all use/wen/mem/br flags forced 0; field bits stored unchanged.
- Enqueue when in_valid && in_ready: write entry at tail, tail <= tail+1, wrapping DEPTH-1 -> 0.
- Dequeue when out_valid && out_ready: head <= head+1, same wrap.
- out_valid = (count != 0). When empty, all out_* data outputs are 0.
- Latency: accepted at edge T -> visible on outputs from T+1.
- Enqueue and dequeue in the same cycle: count unchanged, both pointers advance.
- When full, in_ready=0 even if out_ready=1; no same-cycle pass-through. Keeps in_ready free of combinational paths.
- in_valid without in_ready: instruction not captured; fetch must hold it.
- flush=1: at the next edge head, tail and count go to 0. Any enqueue or dequeue in that cycle is discarded. Flush has priority over both.
- rst: same effect as flush. Reset values: out_valid=0, in_ready=1, count=0, all out_* = 0. Storage contents are don't-care.
- Reset or flush mid-stream: the queue is fully empty the cycle after; no partial drain.
- Count is always 0..DEPTH; never overflows or underflows.

Optional Feature:
- Macro: DECODE_QUEUE_BYPASS_EN.
- Defined: when count==0 and in_valid=1 (and no flush), outputs present the combinationally decoded in_inst with out_valid=1 in the same cycle.
  - If out_ready=1 that cycle, the instruction is consumed and not written.
  - Otherwise it is enqueued normally.
- Undefined: minimum latency is 1 cycle as above; out_* depend only on registers.

Decomposition:
- Add to the shared param include:
  - `DQ_ENTRY_LEN, packed decoded-entry width.
  - `DQ_* bit-slice macros for each field within the entry.
  - INST_OP_* opcodes and width macros already live there.
- Sub-module inst_field_dec: combinational raw-instruction-to-packed-entry decoder with illegal-opcode flag.
- The FIFO body is an array of `DQ_ENTRY_LEN registers plus pointer and count logic.

Test Plan:
- Fill/drain, DEPTH=4: enqueue ADD r1,r2->r3; LI; LD; ST with out_ready=0. Expect count=4, in_ready=0. Then out_ready=1 for 4 cycles: entries exit in order with correct flags (ADD: rs1_used=1, rs2_used=1, wen=1). Expect count=0.
- Simultaneous enqueue/dequeue at count=2 for 10 cycles: count stays 2, order preserved across pointer wrap.
- Flush with count=3 while in_valid=1 and out_ready=1: next cycle count=0, out_valid=0, the presented instruction is not stored.
- Illegal opcode (unused encoding) followed by BR: illegal entry shows out_illegal=1 with all flags 0. BR shows is_br=1, rs2_used=1, wen=0.
- Reset asserted with count=2: next cycle out_valid=0, in_ready=1, all outputs 0; subsequent enqueue appears after 1 cycle.
- With DECODE_QUEUE_BYPASS_EN, empty queue, in_valid=1, out_ready=1 for MUL: out_valid=1 in the same cycle, count stays 0.
